// File: rtl/maxnet_host_if.sv
// Job/result handshake bundle between a job source, a result sink and maxnet_host.
// The host-side driver uses the slave modport; the job source/result sink uses master.
interface maxnet_host_if #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 5
);
    logic                   job_valid;
    logic                   job_ready;
    logic [N_IN*DATA_W-1:0] job_data;
    logic                   res_valid;
    logic                   res_ready;
    logic [RES_W-1:0]       res_data;

    modport master (
        output job_valid, job_data, res_ready,
        input  job_ready, res_valid, res_data
    );

    modport slave (
        input  job_valid, job_data, res_ready,
        output job_ready, res_valid, res_data
    );
endinterface

// File: rtl/maxnet_host.sv
// Host-side driver for maxnet: load N_IN values into its input memory, pulse start, capture the winner.
// Optional WAIT abort counter enabled by defining MAXNET_HOST_TIMEOUT_EN.
module maxnet_host #(
    parameter int N_IN    = 4,
    parameter int DATA_W  = 8,
    parameter int RES_W   = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    maxnet_host_if.slave            host,
    output logic                    mem_we,
    output logic [$clog2(N_IN)-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mn_start,
    input  logic                    mn_done,
    input  logic [RES_W-1:0]        mn_result,
    output logic                    busy,
    output logic                    timeout
);
    localparam int AW = $clog2(N_IN);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;

    state_t                 state_reg, state_next;
    logic [N_IN*DATA_W-1:0] job_reg, job_next;
    logic [DATA_W-1:0]      vals [N_IN];
    logic                   job_ready_reg, job_ready_next;
    logic                   mem_we_reg, mem_we_next;
    logic [AW-1:0]          mem_addr_reg, mem_addr_next, addr_inc;
    logic [DATA_W-1:0]      mem_wdata_reg, mem_wdata_next;
    logic                   mn_start_reg, mn_start_next;
    logic                   res_valid_reg, res_valid_next;
    logic [RES_W-1:0]       res_data_reg, res_data_next;
    logic                   busy_reg, busy_next;
    logic                   accept;
    logic                   last_write;
    logic                   wait_abort;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign vals[gi] = job_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign addr_inc   = mem_addr_reg + 1'b1;
    assign last_write = (mem_addr_reg == AW'(N_IN - 1));

`ifdef MAXNET_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_reg;
    logic          timeout_reg;

    // Counter is 0 in the first WAIT cycle, so the abort fires at the end of the TIMEOUT-th cycle.
    assign wait_abort = (state_reg == WAIT) && !mn_done && (wait_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
            if (accept)
                timeout_reg <= 1'b0;
            else if (wait_abort)
                timeout_reg <= 1'b1;
        end
    end

    assign timeout = timeout_reg;
`else
    assign wait_abort = 1'b0;
    // Constant 0; the comparison only keeps TIMEOUT referenced in this build.
    assign timeout    = (TIMEOUT < 0);
`endif

    always_comb begin
        state_next     = state_reg;
        job_next       = job_reg;
        job_ready_next = job_ready_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mn_start_next  = 1'b0;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        accept         = 1'b0;

        case (state_reg)
            IDLE: begin
                job_ready_next = 1'b1;
                if (host.job_valid && job_ready_reg) begin
                    // Address 0 is issued straight from the bus so the first write lands at edge 1.
                    accept         = 1'b1;
                    job_next       = host.job_data;
                    job_ready_next = 1'b0;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = '0;
                    mem_wdata_next = host.job_data[DATA_W-1:0];
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                if (last_write) begin
                    mn_start_next = 1'b1;
                    state_next    = START;
                end else begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = addr_inc;
                    mem_wdata_next = vals[addr_inc];
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mn_done) begin
                    res_data_next  = mn_result;
                    res_valid_next = 1'b1;
                    state_next     = OUT;
                end else if (wait_abort) begin
                    res_data_next  = '1;
                    res_valid_next = 1'b1;
                    state_next     = OUT;
                end
            end
            OUT: begin
                if (host.res_ready) begin
                    res_valid_next = 1'b0;
                    job_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            job_reg       <= '0;
            job_ready_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mn_start_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            job_reg       <= job_next;
            job_ready_reg <= job_ready_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mn_start_reg  <= mn_start_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            busy_reg      <= busy_next;
        end
    end

    assign host.job_ready = job_ready_reg;
    assign host.res_valid = res_valid_reg;
    assign host.res_data  = res_data_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign mn_start       = mn_start_reg;
    assign busy           = busy_reg;
endmodule

// File: tb/tb_maxnet_host.sv
// Scoreboard bench for maxnet_host: a maxnet stub picks the largest stored value (lowest index on ties);
// expected writes/results are queued at job accept and checked by an independent monitor.
module tb_maxnet_host;
    localparam int N_IN   = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 5;
    localparam int TMO    = 20;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    mem_we;
    logic [$clog2(N_IN)-1:0] mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mn_start;
    logic                    mn_done = 1'b0;
    logic [RES_W-1:0]        mn_result = '0;
    logic                    busy;
    logic                    timeout;

    maxnet_host_if #(.N_IN(N_IN), .DATA_W(DATA_W), .RES_W(RES_W)) hif ();

    maxnet_host #(.N_IN(N_IN), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (hif.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mn_start  (mn_start),
        .mn_done   (mn_done),
        .mn_result (mn_result),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int res; bit to; } res_t;
    wr_t  exp_wr[$];
    res_t exp_res[$];

    int checks = 0;
    int passed = 0;

    // Stub and driver controls
    int stub_delay   = 10;
    bit stub_level   = 1'b0;
    bit stub_never   = 1'b0;
    int stub_cnt     = -1;
    bit stub_drop    = 1'b0;
    logic [DATA_W-1:0] stub_mem [N_IN];
    logic [RES_W-1:0]  stub_win = '0;
    int done_set_cyc = -100;
    int start_cyc    = -100;
    int accept_edge  = -100;
    int last_hs_edge = -1;
    bit b2b          = 1'b0;
    bit tmo_expect   = 1'b0;
    int rr_mode      = 2;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: actual=event-missing-or-extra required=none cycle=%0d", name, cyc);
    endtask

    function automatic int argmax(input logic [N_IN*DATA_W-1:0] d);
        int best = 0;
        for (int i = 1; i < N_IN; i++)
            if (d[i*DATA_W +: DATA_W] > d[best*DATA_W +: DATA_W]) best = i;
        return best;
    endfunction

    // maxnet stub: remembers written values, answers stub_delay cycles after start.
    initial begin
        logic [N_IN*DATA_W-1:0] packed_mem;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                stub_mem[mem_addr] = mem_wdata;
                if (stub_level && mn_done && mem_addr == 0) mn_result = 5'h1D;
            end
            if (stub_drop) begin
                mn_done   = 1'b0;
                stub_drop = 1'b0;
            end else if (!stub_level && mn_done) begin
                mn_done = 1'b0;
            end
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    mn_done      = 1'b1;
                    mn_result    = stub_win;
                    done_set_cyc = cyc;
                    stub_cnt     = -1;
                end
            end
            if (mn_start) begin
                for (int i = 0; i < N_IN; i++) packed_mem[i*DATA_W +: DATA_W] = stub_mem[i];
                stub_win  = RES_W'(argmax(packed_mem));
                start_cyc = cyc;
                if (stub_level) stub_drop = 1'b1;
                if (!stub_never) stub_cnt = stub_delay;
            end
        end
    end

    // Result consumer
    initial begin
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       hif.res_ready = ($urandom_range(0, 3) != 0);
                1:       hif.res_ready = 1'b1;
                default: hif.res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT writes, starts or hands over a result.
    initial begin
        bit               prev_start = 1'b0;
        bit               prev_valid = 1'b0;
        bit               prev_ready = 1'b0;
        logic [RES_W-1:0] prev_data  = '0;
        wr_t              w;
        res_t             r;
        forever begin
            @(negedge clk);
            #1;
            if (mem_we) begin
                if (exp_wr.size() == 0) fail("wr_unexpected");
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                    check("wr_latency", cyc + 1 - accept_edge, w.addr + 1);
                end
            end
            if (mn_start) begin
                check("start_width", prev_start, 0);
                check("start_latency", cyc + 1 - accept_edge, N_IN + 1);
                check("start_after_writes", exp_wr.size(), 0);
            end
            prev_start = mn_start;

            if (hif.res_valid && !prev_valid) begin
                if (exp_res.size() > 0 && exp_res[0].to)
                    check("timeout_latency", cyc - start_cyc, TMO + 1);
                else
                    check("res_latency", cyc - done_set_cyc, 1);
            end
            if (prev_valid && !prev_ready) begin
                check("res_hold_valid", hif.res_valid, 1);
                check("res_hold_data", hif.res_data, prev_data);
            end
            if (hif.res_valid) begin
                check("busy_in_out", busy, 1);
                check("job_ready_in_out", hif.job_ready, 0);
            end
            if (hif.res_valid && hif.res_ready) begin
                last_hs_edge = cyc + 1;
                if (exp_res.size() == 0) fail("res_unexpected");
                else begin
                    r = exp_res.pop_front();
                    check("res_data", hif.res_data, r.res);
                    check("res_timeout", timeout, r.to);
                    $display("result: data=%0h timeout=%0b cycle=%0d", hif.res_data, timeout, cyc);
                end
            end
            prev_valid = hif.res_valid;
            prev_ready = hif.res_ready;
            prev_data  = hif.res_data;
        end
    end

    task automatic send_job(input logic [N_IN*DATA_W-1:0] d);
        int   n = 0;
        res_t r;
        forever begin
            @(negedge clk);
            hif.job_valid = 1'b1;
            hif.job_data  = d;
            if (hif.job_ready) break;
            n++;
            if (n > 400) begin
                fail("job_accept_timeout");
                return;
            end
        end
        accept_edge = cyc + 1;
        if (b2b && last_hs_edge >= 0) check("b2b_accept_edge", accept_edge, last_hs_edge + 1);
        for (int i = 0; i < N_IN; i++) exp_wr.push_back('{i, int'(d[i*DATA_W +: DATA_W])});
        r.res = tmo_expect ? 31 : argmax(d);
        r.to  = tmo_expect;
        exp_res.push_back(r);
        $display("job: data=%08h expect=%0h timeout=%0b cycle=%0d", d, r.res, r.to, cyc);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        hif.job_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (exp_res.size() == 0 && !busy && !hif.res_valid) return;
        end
        fail("wait_idle_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_job_ready"}, hif.job_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, hif.res_valid, 0);
        check({tag, "_res_data"}, hif.res_data, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mn_start"}, mn_start, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        hif.job_valid = 1'b0;
        hif.job_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("job_ready_after_reset", hif.job_ready, 1);
        check("busy_after_reset", busy, 0);

        // Directed job with a stalled result consumer
        stub_delay = 10;
        rr_mode    = 2;
        send_job(32'h28C8075A);
        drop_valid();
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = hif.res_valid;
        end
        if (!seen) fail("directed_res_valid");
        repeat (5) @(negedge clk);
        #1;
        check("stall_job_ready", hif.job_ready, 0);
        check("stall_busy", busy, 1);
        rr_mode = 1;
        wait_idle();

        // mn_done left high by the previous job must not be captured early
        stub_level = 1'b1;
        stub_delay = 4;
        send_job(32'h10_20_F0_30);
        send_job(32'hE0_11_22_33);
        drop_valid();
        wait_idle();
        stub_level = 1'b0;
        mn_done    = 1'b0;

        // Reset during WAIT aborts silently
        stub_delay = 12;
        send_job($urandom());
        drop_valid();
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = mn_start;
        end
        if (!seen) fail("reset_test_start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midjob_reset");
        exp_res.delete();
        exp_wr.delete();
        @(negedge clk);
        #1;
        check("job_ready_after_abort", hif.job_ready, 1);
        repeat (20) @(negedge clk);
        #1;
        check("no_result_after_abort", hif.res_valid, 0);

`ifdef MAXNET_HOST_TIMEOUT_EN
        stub_never = 1'b1;
        tmo_expect = 1'b1;
        send_job($urandom());
        drop_valid();
        wait_idle();
        check("timeout_sticky", timeout, 1);
        stub_never = 1'b0;
        tmo_expect = 1'b0;
        stub_delay = 3;
        send_job($urandom());
        drop_valid();
        #1;
        check("timeout_cleared_on_accept", timeout, 0);
        wait_idle();
`endif

        // Back-to-back randomized jobs
        b2b          = 1'b1;
        last_hs_edge = -1;
        for (int j = 0; j < 30; j++) begin
            rr_mode    = (j < 10) ? 1 : 0;
            stub_delay = $urandom_range(1, 12);
            stub_level = (j >= 10) && ($urandom_range(0, 1) == 1);
            send_job($urandom());
        end
        drop_valid();
        wait_idle();
        b2b     = 1'b0;
        rr_mode = 1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
